// File: rtl/time_keeper_if.sv
// Bundle between the timekeeping core and whoever drives it: mode and
// push-buttons in, BCD digits, setup location and seconds strobe out.
interface time_keeper_if;
    logic [1:0] mode;
    logic       btn_next;
    logic       btn_inc;
    logic [3:0] hoursUpper;
    logic [3:0] hoursLower;
    logic [3:0] minutesUpper;
    logic [3:0] minutesLower;
    logic [3:0] secondsUpper;
    logic [3:0] secondsLower;
    logic [1:0] location;
    logic       sec_pulse;

    // Controller / bench side
    modport master (
        output mode, btn_next, btn_inc,
        input  hoursUpper, hoursLower, minutesUpper, minutesLower,
               secondsUpper, secondsLower, location, sec_pulse
    );

    // Timekeeping core side
    modport slave (
        input  mode, btn_next, btn_inc,
        output hoursUpper, hoursLower, minutesUpper, minutesLower,
               secondsUpper, secondsLower, location, sec_pulse
    );
endinterface

// File: rtl/time_keeper.sv
// 24-hour BCD timekeeping core. SETUP mode edits HH:MM one digit at a time
// via debounced buttons; every other mode counts seconds from a prescaler.
module time_keeper #(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int PRESC_W       = 26
) (
    input  logic         clk,
    input  logic         rst,
    time_keeper_if.slave tk
);

    localparam logic [PRESC_W-1:0] TERM  = PRESC_W'(TICKS_PER_SEC - 1);
    localparam logic [1:0]         SETUP = 2'b00;

    // [0],[1] synchronizer stages, [2] edge register
    logic [2:0] next_sync, inc_sync;
    logic       next_pulse, inc_pulse;

    logic [3:0] hu, hl, mu, ml, su, sl;
    logic [3:0] hu_n, hl_n, mu_n, ml_n, su_n, sl_n;
    logic [1:0] loc;
    logic [PRESC_W-1:0] presc;
    logic       sec_pulse_q;
    logic       tick;

    // Bring the asynchronous button levels into clk and keep one delayed copy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            next_sync <= '0;
            inc_sync  <= '0;
        end else begin
            next_sync <= {next_sync[1:0], tk.btn_next};
            inc_sync  <= {inc_sync[1:0], tk.btn_inc};
        end
    end

    assign next_pulse = next_sync[1] & ~next_sync[2];
    assign inc_pulse  = inc_sync[1] & ~inc_sync[2];

    // >= keeps the counter from running away if it ever holds a value past terminal
    assign tick = (presc >= TERM);

    // Next-second values: full BCD cascade, out-of-range digits fall back to 0
    always_comb begin
        hu_n = hu; hl_n = hl; mu_n = mu; ml_n = ml; su_n = su; sl_n = sl;
        if (sl >= 4'd9) begin
            sl_n = 4'd0;
            if (su >= 4'd5) begin
                su_n = 4'd0;
                if (ml >= 4'd9) begin
                    ml_n = 4'd0;
                    if (mu >= 4'd5) begin
                        mu_n = 4'd0;
                        if (hu > 4'd2 || (hu == 4'd2 && hl >= 4'd3)) begin
                            hu_n = 4'd0;
                            hl_n = 4'd0;
                        end else if (hl >= 4'd9) begin
                            hu_n = hu + 4'd1;
                            hl_n = 4'd0;
                        end else begin
                            hl_n = hl + 4'd1;
                        end
                    end else begin
                        mu_n = mu + 4'd1;
                    end
                end else begin
                    ml_n = ml + 4'd1;
                end
            end else begin
                su_n = su + 4'd1;
            end
        end else begin
            sl_n = sl + 4'd1;
        end
    end

    // Setup editing or once-per-second counting, depending on mode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hu <= '0; hl <= '0; mu <= '0; ml <= '0; su <= '0; sl <= '0;
            loc         <= '0;
            presc       <= '0;
            sec_pulse_q <= 1'b0;
        end else if (tk.mode == SETUP) begin
            presc       <= '0;
            su          <= '0;
            sl          <= '0;
            sec_pulse_q <= 1'b0;
            // inc acts on the current location even when next fires in the same cycle
            if (inc_pulse) begin
                unique case (loc)
                    2'd0: begin
                        if (hu >= 4'd2) begin
                            hu <= 4'd0;
                        end else begin
                            hu <= hu + 4'd1;
                            // 20..23 only: pull hours units down when tens becomes 2
                            if (hu == 4'd1 && hl > 4'd3) hl <= 4'd3;
                        end
                    end
                    2'd1: begin
                        if (hl >= 4'd9 || (hu == 4'd2 && hl >= 4'd3)) hl <= 4'd0;
                        else                                          hl <= hl + 4'd1;
                    end
                    2'd2: mu <= (mu >= 4'd5) ? 4'd0 : mu + 4'd1;
                    2'd3: ml <= (ml >= 4'd9) ? 4'd0 : ml + 4'd1;
                endcase
            end
            if (next_pulse) loc <= loc + 2'd1;
        end else begin
            sec_pulse_q <= tick;
            if (tick) begin
                presc <= '0;
                hu <= hu_n; hl <= hl_n; mu <= mu_n;
                ml <= ml_n; su <= su_n; sl <= sl_n;
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

    assign tk.hoursUpper   = hu;
    assign tk.hoursLower   = hl;
    assign tk.minutesUpper = mu;
    assign tk.minutesLower = ml;
    assign tk.secondsUpper = su;
    assign tk.secondsLower = sl;
    assign tk.location     = loc;
    assign tk.sec_pulse    = sec_pulse_q;

endmodule

// File: tb/tb_time_keeper.sv
// Directed bench for time_keeper with a 10-cycle second.
module tb_time_keeper;

    localparam int TPS = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    time_keeper_if tkif ();

    time_keeper #(.TICKS_PER_SEC(TPS), .PRESC_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .tk  (tkif.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    function automatic logic [23:0] tnow();
        return {tkif.hoursUpper, tkif.hoursLower, tkif.minutesUpper,
                tkif.minutesLower, tkif.secondsUpper, tkif.secondsLower};
    endfunction

    function automatic logic [3:0] digit(input int l);
        case (l)
            0:       return tkif.hoursUpper;
            1:       return tkif.hoursLower;
            2:       return tkif.minutesUpper;
            default: return tkif.minutesLower;
        endcase
    endfunction

    // Advance n rising edges, then settle 1 time unit past the edge
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input bit nxt, input bit inc);
        tkif.btn_next = nxt;
        tkif.btn_inc  = inc;
        step(4);
        tkif.btn_next = 1'b0;
        tkif.btn_inc  = 1'b0;
        step(3);
    endtask

    task automatic goto_loc(input int l);
        for (int k = 0; k < 4 && tkif.location != 2'(l); k++) press(1'b1, 1'b0);
        if (tkif.location !== 2'(l)) begin
            $display("FAIL goto_loc: location %0d, want %0d", tkif.location, l);
            n_err++;
        end
        n_vec++;
    endtask

    task automatic set_digit(input int l, input logic [3:0] v);
        goto_loc(l);
        for (int k = 0; k < 10 && digit(l) != v; k++) press(1'b0, 1'b1);
        if (digit(l) !== v) begin
            $display("FAIL set_digit%0d: got %h, want %h", l, digit(l), v);
            n_err++;
        end
        n_vec++;
    endtask

    task automatic set_time(input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] c, input logic [3:0] d);
        tkif.mode = 2'b00;
        step(2);
        set_digit(0, a);
        set_digit(1, b);
        set_digit(2, c);
        set_digit(3, d);
        if (tnow() !== {a, b, c, d, 8'h00}) begin
            $display("FAIL set_time: got %h, want %h", tnow(), {a, b, c, d, 8'h00});
            n_err++;
        end
        n_vec++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tkif.mode = 2'b01;
        tkif.btn_next = 1'b0;
        tkif.btn_inc  = 1'b0;
        #12;
        if (tnow() !== 24'h000000) begin
            $display("FAIL reset_time: got %h, want 000000", tnow()); n_err++;
        end
        n_vec++;
        if (tkif.location !== 2'd0 || tkif.sec_pulse !== 1'b0) begin
            $display("FAIL reset_ctl: loc %0d pulse %b, want 0 0", tkif.location, tkif.sec_pulse);
            n_err++;
        end
        n_vec++;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_count();
        int pulses = 0, last = 0, bad = 0;
        for (int i = 1; i <= 600; i++) begin
            step(1);
            if (tkif.sec_pulse === 1'b1) begin
                pulses++;
                if (i - last != TPS) bad++;
                last = i;
            end
        end
        if (pulses != 60) begin
            $display("FAIL count_pulses: got %0d, want 60", pulses); n_err++;
        end
        n_vec++;
        if (bad != 0) begin
            $display("FAIL count_spacing: %0d bad gaps, want 0", bad); n_err++;
        end
        n_vec++;
        if (tnow() !== 24'h000100) begin
            $display("FAIL count_time: got %h, want 000100", tnow()); n_err++;
        end
        n_vec++;
    endtask

    task automatic test_rollover(input logic [7:0] hh, input logic [7:0] nh);
        set_time(hh[7:4], hh[3:0], 4'd5, 4'd9);
        tkif.mode = 2'b01;
        step(590);
        if (tnow() !== {hh, 16'h5959}) begin
            $display("FAIL roll_pre: got %h, want %h", tnow(), {hh, 16'h5959}); n_err++;
        end
        n_vec++;
        step(9);
        if (tkif.sec_pulse !== 1'b0 || tnow() !== {hh, 16'h5959}) begin
            $display("FAIL roll_early: pulse %b time %h, want 0 %h", tkif.sec_pulse, tnow(), {hh, 16'h5959});
            n_err++;
        end
        n_vec++;
        step(1);
        if (tkif.sec_pulse !== 1'b1 || tnow() !== {nh, 16'h0000}) begin
            $display("FAIL roll_edge: pulse %b time %h, want 1 %h", tkif.sec_pulse, tnow(), {nh, 16'h0000});
            n_err++;
        end
        n_vec++;
    endtask

    task automatic test_setup_clamp();
        set_time(4'd1, 4'd9, 4'd0, 4'd0);
        goto_loc(0);
        press(1'b0, 1'b1);
        if (tnow() !== 24'h230000) begin
            $display("FAIL clamp: got %h, want 230000", tnow()); n_err++;
        end
        n_vec++;
        goto_loc(1);
        for (int k = 0; k < 3; k++) begin
            press(1'b0, 1'b1);
            if (tnow() !== {8'h20 + 8'(k), 16'h0000}) begin
                $display("FAIL hl_wrap%0d: got %h, want %h", k, tnow(), {8'h20 + 8'(k), 16'h0000});
                n_err++;
            end
            n_vec++;
        end
    endtask

    task automatic test_location();
        goto_loc(0);
        for (int k = 1; k <= 5; k++) begin
            press(1'b1, 1'b0);
            if (tkif.location !== 2'(k % 4)) begin
                $display("FAIL loc_step%0d: got %0d, want %0d", k, tkif.location, k % 4); n_err++;
            end
            n_vec++;
        end
        set_time(4'd2, 4'd2, 4'd5, 4'd4);
        goto_loc(2);
        press(1'b1, 1'b1);
        if (tnow() !== 24'h220400 || tkif.location !== 2'd3) begin
            $display("FAIL next_inc: time %h loc %0d, want 220400 3", tnow(), tkif.location); n_err++;
        end
        n_vec++;
        tkif.btn_inc = 1'b1;
        step(100);
        tkif.btn_inc = 1'b0;
        step(3);
        if (tnow() !== 24'h220500) begin
            $display("FAIL held_inc: got %h, want 220500", tnow()); n_err++;
        end
        n_vec++;
    endtask

    task automatic test_run_ignore();
        int bad = 0, first = 0;
        tkif.mode = 2'b01;
        tkif.btn_next = 1'b1;
        tkif.btn_inc  = 1'b1;
        step(3);
        tkif.btn_next = 1'b0;
        tkif.btn_inc  = 1'b0;
        step(2);
        if (tnow() !== 24'h220500 || tkif.location !== 2'd3) begin
            $display("FAIL run_btn: time %h loc %0d, want 220500 3", tnow(), tkif.location); n_err++;
        end
        n_vec++;
        step(5);
        if (tkif.sec_pulse !== 1'b1 || tnow() !== 24'h220501) begin
            $display("FAIL run_tick: pulse %b time %h, want 1 220501", tkif.sec_pulse, tnow()); n_err++;
        end
        n_vec++;
        step(7);
        tkif.mode = 2'b00;
        step(1);
        if (tnow() !== 24'h220500 || tkif.sec_pulse !== 1'b0) begin
            $display("FAIL setup_clear: time %h pulse %b, want 220500 0", tnow(), tkif.sec_pulse); n_err++;
        end
        n_vec++;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (tkif.sec_pulse !== 1'b0 || tnow() !== 24'h220500) bad++;
        end
        if (bad != 0) begin
            $display("FAIL setup_hold: %0d bad cycles, want 0", bad); n_err++;
        end
        n_vec++;
        tkif.mode = 2'b01;
        for (int i = 1; i <= 30 && first == 0; i++) begin
            step(1);
            if (tkif.sec_pulse === 1'b1) first = i;
        end
        if (first != TPS) begin
            $display("FAIL first_tick: at cycle %0d, want %0d", first, TPS); n_err++;
        end
        n_vec++;
    endtask

    task automatic test_async_reset();
        #2;
        rst = 1'b1;
        #1;
        if (tnow() !== 24'h000000 || tkif.location !== 2'd0 || tkif.sec_pulse !== 1'b0) begin
            $display("FAIL async_rst: time %h loc %0d pulse %b, want 000000 0 0",
                     tnow(), tkif.location, tkif.sec_pulse);
            n_err++;
        end
        n_vec++;
        #3;
        rst = 1'b0;
        step(1);
    endtask

    initial begin
        test_reset();
        test_count();
        test_rollover(8'h23, 8'h00);
        test_rollover(8'h09, 8'h10);
        test_rollover(8'h19, 8'h20);
        test_setup_clamp();
        test_location();
        test_run_ignore();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
